uart_alu_frame_if: RTL and testbench

- Framed UART-to-ALU command interface: receives a start byte, multi-byte operands A and B, an opcode and an XOR checksum from the RX FIFO.
- Launches one ALU operation and returns a status byte plus the multi-byte result through the TX FIFO.
- Generalises the single-byte command handler with operand width N_BYTES*NB_DATA, checksum validation, inter-byte timeout and error status reporting.
- Sits between uart_rx/rx FIFO, the ALU and the tx FIFO/uart_tx.

---
 rtl/uart_alu_frame_if.sv | 210 +++++++++++++++++++++
 tb/tb_uart_alu_frame_if.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_frame_if.sv
// uart_alu_frame_if
//   Framed command interface between a UART RX FIFO, an ALU and a UART TX FIFO.
//   Frame on the RX side : START, A[0..N-1], B[0..N-1], OP, CHK (operands LSB first).
//   CHK is the XOR of every A, B and OP byte (the start byte is not included).
//   Response on the TX side: one status byte, followed by the N result bytes
//   (LSB first) when the status is ST_OK.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   rx_data      : head of the RX FIFO (first-word-fall-through)
//   rx_empty     : RX FIFO empty
//   rx_rd        : pop RX FIFO; the byte is consumed on the same edge
//   tx_full      : TX FIFO full
//   tx_wr        : push tx_data into the TX FIFO
//   tx_data      : byte to transmit (0 when tx_wr is low)
//   alu_a/alu_b  : registered operands
//   alu_op       : registered opcode
//   alu_start    : one-cycle launch pulse
//   alu_result   : ALU result, captured on alu_valid
//   alu_valid    : result strobe
//   busy         : high whenever the FSM is not idle
//   frame_err    : one-cycle pulse on checksum or timeout error
module uart_alu_frame_if #(
    parameter int                 NB_DATA    = 8,
    parameter int                 N_BYTES    = 2,
    parameter int                 NB_OP      = 6,
    parameter logic [NB_DATA-1:0] START_BYTE = 'hFF,
    parameter int                 TIMEOUT    = 1000,
    parameter logic [NB_DATA-1:0] ST_OK      = 'h00,
    parameter logic [NB_DATA-1:0] ST_CHK     = 'hE1,
    parameter logic [NB_DATA-1:0] ST_TO      = 'hE2,
    localparam int                NB_W       = NB_DATA * N_BYTES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NB_DATA-1:0] rx_data,
    input  logic               rx_empty,
    output logic               rx_rd,
    input  logic               tx_full,
    output logic               tx_wr,
    output logic [NB_DATA-1:0] tx_data,
    output logic [NB_W-1:0]    alu_a,
    output logic [NB_W-1:0]    alu_b,
    output logic [NB_OP-1:0]   alu_op,
    output logic               alu_start,
    input  logic [NB_W-1:0]    alu_result,
    input  logic               alu_valid,
    output logic               busy,
    output logic               frame_err
);

    localparam int NB_BC = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int NB_TO = $clog2(TIMEOUT);
    localparam logic [NB_BC-1:0] BC_LAST = NB_BC'(N_BYTES - 1);
    localparam logic [NB_TO-1:0] TO_LAST = NB_TO'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, RX_A, RX_B, RX_OP, RX_CHK, ALU_START, ALU_WAIT, TX_STATUS, TX_RES
    } state_t;

    state_t state, state_n;

    logic [N_BYTES-1:0][NB_DATA-1:0] a_q, a_n, b_q, b_n, res_q, res_n;
    logic [NB_OP-1:0]                op_q, op_n;
    logic [NB_DATA-1:0]              chk_q, chk_n, status_q, status_n;
    logic [NB_BC-1:0]                cnt_q, cnt_n;
    logic [NB_TO-1:0]                to_q, to_n;
    logic                            in_rx;

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            op_q     <= '0;
            chk_q    <= '0;
            status_q <= '0;
            cnt_q    <= '0;
            to_q     <= '0;
        end else begin
            state    <= state_n;
            a_q      <= a_n;
            b_q      <= b_n;
            res_q    <= res_n;
            op_q     <= op_n;
            chk_q    <= chk_n;
            status_q <= status_n;
            cnt_q    <= cnt_n;
            to_q     <= to_n;
        end
    end

    always_comb begin
        state_n   = state;
        a_n       = a_q;
        b_n       = b_q;
        res_n     = res_q;
        op_n      = op_q;
        chk_n     = chk_q;
        status_n  = status_q;
        cnt_n     = cnt_q;
        to_n      = to_q;
        rx_rd     = 1'b0;
        tx_wr     = 1'b0;
        tx_data   = '0;
        alu_start = 1'b0;
        frame_err = 1'b0;

        in_rx = (state == RX_A) || (state == RX_B) || (state == RX_OP) || (state == RX_CHK);
        if (state == IDLE || in_rx)
            rx_rd = !rx_empty;

        // Inter-byte watchdog: a byte present in the expiry cycle is consumed
        // instead, so rx_rd takes priority over the timeout.
        if (in_rx) begin
            if (rx_rd) begin
                to_n = '0;
            end else if (to_q == TO_LAST) begin
                status_n  = ST_TO;
                frame_err = 1'b1;
                state_n   = TX_STATUS;
            end else begin
                to_n = to_q + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (rx_rd && rx_data == START_BYTE) begin
                    chk_n   = '0;
                    cnt_n   = '0;
                    to_n    = '0;
                    state_n = RX_A;
                end
            end
            RX_A: begin
                if (rx_rd) begin
                    a_n[cnt_q] = rx_data;
                    chk_n      = chk_q ^ rx_data;
                    cnt_n      = (cnt_q == BC_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == BC_LAST)
                        state_n = RX_B;
                end
            end
            RX_B: begin
                if (rx_rd) begin
                    b_n[cnt_q] = rx_data;
                    chk_n      = chk_q ^ rx_data;
                    cnt_n      = (cnt_q == BC_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == BC_LAST)
                        state_n = RX_OP;
                end
            end
            RX_OP: begin
                if (rx_rd) begin
                    chk_n   = chk_q ^ rx_data;
                    op_n    = rx_data[NB_OP-1:0];
                    state_n = RX_CHK;
                end
            end
            RX_CHK: begin
                if (rx_rd) begin
                    if (rx_data == chk_q) begin
                        state_n = ALU_START;
                    end else begin
                        status_n  = ST_CHK;
                        frame_err = 1'b1;
                        state_n   = TX_STATUS;
                    end
                end
            end
            ALU_START: begin
                alu_start = 1'b1;
                state_n   = ALU_WAIT;
            end
            ALU_WAIT: begin
                if (alu_valid) begin
                    res_n    = alu_result;
                    status_n = ST_OK;
                    state_n  = TX_STATUS;
                end
            end
            TX_STATUS: begin
                tx_wr = !tx_full;
                if (!tx_full) begin
                    tx_data = status_q;
                    cnt_n   = '0;
                    state_n = (status_q == ST_OK) ? TX_RES : IDLE;
                end
            end
            TX_RES: begin
                tx_wr = !tx_full;
                if (!tx_full) begin
                    tx_data = res_q[cnt_q];
                    cnt_n   = (cnt_q == BC_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == BC_LAST)
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_alu_frame_if.sv
// Bench for uart_alu_frame_if (N_BYTES=2, NB_OP=6, TIMEOUT=16).
// Behavioural RX/TX FIFOs around the DUT; a vector table for whole frames plus
// hand-written sequences for garbage, timeout, TX back-pressure and reset.
module tb_uart_alu_frame_if;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rx_rd;
    logic        tx_full;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [5:0]  alu_op;
    logic        alu_start, alu_valid, busy, frame_err;

    always #5 clk = ~clk;

    uart_alu_frame_if #(.NB_DATA(8), .N_BYTES(2), .NB_OP(6), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty), .rx_rd(rx_rd),
        .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_result(alu_result), .alu_valid(alu_valid), .busy(busy), .frame_err(frame_err)
    );

    // RX FIFO model (first-word-fall-through)
    logic [7:0] rx_mem [0:255];
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign rx_data  = rx_mem[rd_ptr[7:0]];
    assign rx_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) if (rx_rd && !rx_empty) rd_ptr <= rd_ptr + 1;

    // TX capture and event counters
    logic [7:0] txq [$];
    int start_cnt = 0, ferr_cnt = 0, viol = 0;
    always @(posedge clk) begin
        if (tx_wr) txq.push_back(tx_data);
        if (tx_wr && tx_full) viol <= viol + 1;
        if (!tx_wr && tx_data != 8'h00) viol <= viol + 1;
        if (alu_start) start_cnt <= start_cnt + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    function automatic logic [7:0] xsum(input logic [15:0] a, input logic [15:0] b, input logic [7:0] o);
        return a[7:0] ^ a[15:8] ^ b[7:0] ^ b[15:8] ^ o;
    endfunction

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] o, input bit bad);
        logic [7:0] c;
        c = xsum(a, b, o) ^ {7'd0, bad};
        push(8'hFF); push(a[7:0]); push(a[15:8]); push(b[7:0]); push(b[15:8]); push(o); push(c);
    endtask

    // Waits for alu_start, checks operands, returns the result and checks the
    // status byte appears one cycle after alu_valid.
    task automatic alu_respond(input logic [15:0] ea, input logic [15:0] eb, input logic [5:0] eo,
                               input logic [15:0] res);
        for (int k = 0; k < 60 && alu_start !== 1'b1; k++) @(negedge clk);
        check("alu_start seen", alu_start, 1);
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        check("alu_op", alu_op, eo);
        @(negedge clk);
        @(negedge clk);
        alu_valid = 1'b1; alu_result = res;
        @(negedge clk);
        alu_valid = 1'b0; alu_result = 16'h0;
        check("status latency tx_wr", tx_wr, 1);
        check("status latency tx_data", tx_data, 8'h00);
    endtask

    task automatic wait_tx(input int n);
        for (int k = 0; k < 80 && !(txq.size() >= n && !busy); k++) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic [7:0]  opb;
        bit          bad;
        logic [5:0]  exp_op;
        logic [15:0] res;
        int          n_tx;
        logic [23:0] tx;     // byte j at [8*j +: 8]
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input int i);
        int s0, e0;
        vec_t v;
        v = vecs[i];
        s0 = start_cnt; e0 = ferr_cnt;
        txq.delete();
        @(negedge clk);
        send_frame(v.a, v.b, v.opb, v.bad);
        if (!v.bad) alu_respond(v.a, v.b, v.exp_op, v.res);
        wait_tx(v.n_tx);
        check($sformatf("v%0d tx count", i), txq.size(), v.n_tx);
        for (int j = 0; j < v.n_tx && j < txq.size(); j++)
            check($sformatf("v%0d tx byte %0d", i, j), txq[j], v.tx[8*j +: 8]);
        check($sformatf("v%0d alu_start pulses", i), start_cnt - s0, v.bad ? 0 : 1);
        check($sformatf("v%0d frame_err pulses", i), ferr_cnt - e0, v.bad ? 1 : 0);
        check($sformatf("v%0d busy idle", i), busy, 0);
    endtask

    initial begin
        int s0, e0;
        bit wr_seen;
        vecs[0] = '{16'h1234, 16'h5678, 8'h20, 1'b0, 6'h20, 16'h68AC, 3, 24'h68AC00};
        vecs[1] = '{16'h1234, 16'h5678, 8'h20, 1'b1, 6'h20, 16'h0000, 1, 24'h0000E1};
        vecs[2] = '{16'h0000, 16'h0000, 8'h00, 1'b0, 6'h00, 16'h0000, 3, 24'h000000};
        vecs[3] = '{16'hFFFF, 16'h0001, 8'h3F, 1'b0, 6'h3F, 16'hBEEF, 3, 24'hBEEF00};
        vecs[4] = '{16'hA5C3, 16'h0F0F, 8'hC5, 1'b0, 6'h05, 16'hB4D2, 3, 24'hB4D200};
        for (int k = 0; k < 256; k++) rx_mem[k] = 8'h00;

        reset = 1'b1; tx_full = 1'b0; alu_valid = 1'b0; alu_result = 16'h0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset tx_wr", tx_wr, 0);
        check("reset rx_rd", rx_rd, 0);
        check("reset alu_a", alu_a, 0);
        check("reset alu_start", alu_start, 0);
        check("reset frame_err", frame_err, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(i);

        // garbage before the start byte
        @(negedge clk);
        push(8'h11); push(8'h22);
        run_vec(0);

        // timeout after FF,34
        txq.delete(); s0 = start_cnt; e0 = ferr_cnt;
        @(negedge clk);
        push(8'hFF); push(8'h34);
        repeat (16) @(negedge clk);
        check("timeout not early", frame_err, 0);
        @(negedge clk);
        check("timeout at 16th idle cycle", frame_err, 1);
        wait_tx(1);
        check("timeout tx count", txq.size(), 1);
        if (txq.size() > 0) check("timeout status", txq[0], 8'hE2);
        check("timeout frame_err pulses", ferr_cnt - e0, 1);
        check("timeout no alu_start", start_cnt - s0, 0);
        run_vec(0);

        // byte arriving on the 16th idle cycle wins
        txq.delete(); e0 = ferr_cnt;
        @(negedge clk);
        push(8'hFF); push(8'h34);
        repeat (17) @(negedge clk);
        push(8'h12);
        #1;
        check("late byte no timeout", frame_err, 0);
        @(negedge clk);
        push(8'h78); push(8'h56); push(8'h20); push(xsum(16'h1234, 16'h5678, 8'h20));
        alu_respond(16'h1234, 16'h5678, 6'h20, 16'h68AC);
        wait_tx(3);
        check("late byte tx count", txq.size(), 3);
        if (txq.size() == 3) check("late byte tx", {txq[2], txq[1], txq[0]}, 24'h68AC00);
        check("late byte frame_err", ferr_cnt - e0, 0);

        // TX back-pressure during TX_RES
        txq.delete();
        @(negedge clk);
        send_frame(16'h1234, 16'h5678, 8'h20, 1'b0);
        alu_respond(16'h1234, 16'h5678, 6'h20, 16'h68AC);
        for (int k = 0; k < 20 && txq.size() < 1; k++) @(negedge clk);
        tx_full = 1'b1;
        wr_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (tx_wr) wr_seen = 1'b1;
        end
        check("stall tx_wr low while full", wr_seen, 0);
        check("stall bytes while full", txq.size(), 1);
        tx_full = 1'b0;
        wait_tx(3);
        check("stall tx count", txq.size(), 3);
        if (txq.size() == 3) check("stall tx order", {txq[2], txq[1], txq[0]}, 24'h68AC00);

        // reset during ALU_WAIT
        txq.delete();
        @(negedge clk);
        send_frame(16'h1234, 16'h5678, 8'h20, 1'b0);
        for (int k = 0; k < 60 && alu_start !== 1'b1; k++) @(negedge clk);
        check("rst alu_start seen", alu_start, 1);
        @(negedge clk);
        push(8'h11);
        @(negedge clk);
        check("rx held while waiting", rx_rd, 0);
        check("busy in ALU_WAIT", busy, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        alu_valid = 1'b1; alu_result = 16'h68AC;
        @(negedge clk);
        alu_valid = 1'b0; alu_result = 16'h0;
        repeat (5) @(negedge clk);
        check("rst no tx", txq.size(), 0);
        check("rst busy", busy, 0);
        check("rst alu_a cleared", alu_a, 0);
        run_vec(0);

        check("tx protocol violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
